// File: rtl/arvi_bus_pkg.sv
// arvi_bus_pkg: shared arbiter state and latched request types
package arvi_bus_pkg;
  localparam int BUS_XLEN = 32;
  typedef enum logic [1:0] {IDLE, BUSY, LOCKED} arb_state_t;
  typedef struct packed {
    logic                wr_en;
    logic [BUS_XLEN-1:0] addr;
    logic [BUS_XLEN-1:0] wr_data;
    logic [3:0]          byte_en;
    logic                lock;
  } bus_req_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector searching upward from last+1 with wrap
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] idx
);
  logic [N-1:0] rot;
  always_comb begin
    rot = N'({req, req} >> (int'(last) + 1));
    valid = |req;
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (rot[i]) idx = IW'((int'(last) + 1 + i) % N);
  end
endmodule

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin merge of N master buses onto one slave port with lock support
module bus_rr_arbiter
  import arvi_bus_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int XLEN      = BUS_XLEN
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_MASTERS-1:0]   i_m_bus_en,
  input  logic [N_MASTERS-1:0]   i_m_wr_en,
  input  logic [N_MASTERS-1:0]   i_m_lock,
  input  logic [N_MASTERS*XLEN-1:0] i_m_addr,
  input  logic [N_MASTERS*XLEN-1:0] i_m_wr_data,
  input  logic [N_MASTERS*4-1:0] i_m_byte_en,
  output logic [N_MASTERS-1:0]   o_m_ack,
  output logic [XLEN-1:0]        o_m_rd_data,
  output logic                   o_s_bus_en,
  output logic                   o_s_wr_en,
  output logic [XLEN-1:0]        o_s_addr,
  output logic [XLEN-1:0]        o_s_wr_data,
  output logic [3:0]             o_s_byte_en,
  input  logic                   i_s_ack,
  input  logic [XLEN-1:0]        i_s_rd_data
);
  localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  arb_state_t state, state_n;
  logic [IW-1:0] grant, grant_n, last_grant, last_n, sel, pick_idx;
  logic pick_valid, ack_hit;
  bus_req_t req, req_n, m_req;
  rr_pick #(.N(N_MASTERS), .IW(IW)) u_pick (
    .req   (i_m_bus_en),
    .last  (last_grant),
    .valid (pick_valid),
    .idx   (pick_idx)
  );
  assign sel = (state == IDLE) ? pick_idx : grant;
  assign m_req = '{
    wr_en:   i_m_wr_en[sel],
    addr:    i_m_addr[sel*XLEN +: XLEN],
    wr_data: i_m_wr_data[sel*XLEN +: XLEN],
    byte_en: i_m_byte_en[sel*4 +: 4],
    lock:    i_m_lock[sel]
  };
  assign ack_hit = (state == BUSY) && i_s_ack && i_rst;
  assign o_s_bus_en = (state == BUSY);
  assign o_s_wr_en = o_s_bus_en & req.wr_en;
  assign o_s_addr = req.addr;
  assign o_s_wr_data = req.wr_data;
  assign o_s_byte_en = req.byte_en;
  assign o_m_ack = ack_hit ? ({{(N_MASTERS-1){1'b0}}, 1'b1} << grant) : '0;
  assign o_m_rd_data = ack_hit ? i_s_rd_data : '0;
  always_comb begin
    state_n = state;
    grant_n = grant;
    last_n = last_grant;
    req_n = req;
    case (state)
      IDLE: if (pick_valid) begin
        grant_n = pick_idx;
        req_n = m_req;
        state_n = BUSY;
      end
      BUSY: if (i_s_ack) begin
        last_n = grant;
        state_n = req.lock ? LOCKED : IDLE;
      end
      LOCKED: if (i_m_bus_en[grant]) begin
        req_n = m_req;
        state_n = BUSY;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state <= IDLE;
      grant <= '0;
      last_grant <= IW'(N_MASTERS - 1);
      req <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      last_grant <= last_n;
      req <= req_n;
    end
  end
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb_bus_rr_arbiter: directed stimulus checked against a transaction-level arbitration model
module tb_bus_rr_arbiter;
  localparam int N = 2;
  localparam int XL = 32;
  logic clk = 0, rst = 0;
  logic [N-1:0] bus_en = '0, wr_en = '0, lock = '0;
  logic [N*XL-1:0] addr = '0, wdata = '0;
  logic [N*4-1:0] be = '0;
  logic [N-1:0] m_ack;
  logic [XL-1:0] m_rd, s_addr, s_wdata;
  logic s_en, s_wr, s_ack;
  logic [3:0] s_be;
  logic [XL-1:0] s_rd = '0;
  logic auto_ack = 0, man_ack = 0, slv_auto = 1;
  int slv_wait = 1;
  int checks = 0, failures = 0;
  bit md_on = 0, md_busy = 0, md_wr = 0, md_lk = 0;
  int md_own = 0, md_last = N - 1, md_lock = -1;
  logic [31:0] md_addr = '0, md_data = '0;
  logic [3:0] md_be = '0;
  int mlog[$];
  logic [N-1:0] alog[$];
  logic [31:0] dlog[$], slog[$];
  int clog[$];
  int cyc = 0, busy_cnt = 0;
  assign s_ack = slv_auto ? auto_ack : man_ack;
  always #5 clk = ~clk;
  bus_rr_arbiter #(.N_MASTERS(N), .XLEN(XL)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m_bus_en(bus_en), .i_m_wr_en(wr_en), .i_m_lock(lock),
    .i_m_addr(addr), .i_m_wr_data(wdata), .i_m_byte_en(be),
    .o_m_ack(m_ack), .o_m_rd_data(m_rd),
    .o_s_bus_en(s_en), .o_s_wr_en(s_wr), .o_s_addr(s_addr),
    .o_s_wr_data(s_wdata), .o_s_byte_en(s_be),
    .i_s_ack(s_ack), .i_s_rd_data(s_rd)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  function automatic logic [63:0] qa(int i);
    return (i < alog.size()) ? 64'(alog[i]) : 64'hBAD;
  endfunction
  function automatic logic [63:0] qd(int i);
    return (i < dlog.size()) ? 64'(dlog[i]) : 64'hBAD;
  endfunction
  function automatic logic [63:0] qs(int i);
    return (i < slog.size()) ? 64'(slog[i]) : 64'hBAD;
  endfunction
  function automatic logic [63:0] qm(int i);
    return (i < mlog.size()) ? 64'(mlog[i]) : 64'hBAD;
  endfunction
  function automatic int qc(int i);
    return (i < clog.size()) ? clog[i] : -1000;
  endfunction
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic set_m(input int k, input logic en, input logic w, input logic lk,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    bus_en[k] = en;
    wr_en[k] = w;
    lock[k] = lk;
    addr[k*XL +: XL] = a;
    wdata[k*XL +: XL] = d;
    be[k*4 +: 4] = b;
  endtask
  task automatic wait_ack(input int k, input string nm);
    int t;
    t = 0;
    @(negedge clk);
    while (!m_ack[k] && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk(nm, 64'(m_ack[k]), 64'd1);
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 0;
    step(2);
    rst = 1;
  endtask
  function automatic int rr_win();
    for (int d = 1; d <= N; d++) begin
      int k;
      k = (md_last + d) % N;
      if (bus_en[k]) return k;
    end
    return -1;
  endfunction
  task automatic model_step();
    int w;
    if (!rst) begin
      md_on = 1;
      md_busy = 0;
      md_lock = -1;
      md_last = N - 1;
      md_addr = '0;
      md_data = '0;
      md_be = '0;
      md_wr = 0;
    end else if (md_busy) begin
      if (s_ack) begin
        md_busy = 0;
        md_last = md_own;
        md_lock = md_lk ? md_own : -1;
        mlog.push_back(md_own);
      end
    end else begin
      w = (md_lock >= 0) ? (bus_en[md_lock] ? md_lock : -1) : rr_win();
      if (w >= 0) begin
        md_busy = 1;
        md_own = w;
        md_wr = wr_en[w];
        md_lk = lock[w];
        md_addr = addr[w*XL +: XL];
        md_data = wdata[w*XL +: XL];
        md_be = be[w*4 +: 4];
      end
    end
  endtask
  task automatic model_loop();
    forever begin
      @(posedge clk);
      model_step();
    end
  endtask
  task automatic compare_loop();
    logic [N-1:0] ea;
    logic [31:0] er;
    bit hit;
    forever begin
      @(negedge clk);
      if (md_on) begin
        hit = md_busy && s_ack && rst;
        ea = hit ? (N'(1) << md_own) : '0;
        er = hit ? s_rd : '0;
        chk("s_bus_en", 64'(s_en), 64'(md_busy));
        chk("m_ack", 64'(m_ack), 64'(ea));
        chk("m_rd_data", 64'(m_rd), 64'(er));
        if (md_busy) begin
          chk("s_wr_en", 64'(s_wr), 64'(md_wr));
          chk("s_addr", 64'(s_addr), 64'(md_addr));
          chk("s_wr_data", 64'(s_wdata), 64'(md_data));
          chk("s_byte_en", 64'(s_be), 64'(md_be));
        end
      end
    end
  endtask
  task automatic logger();
    forever begin
      @(negedge clk);
      cyc++;
      if (s_en) busy_cnt++;
      if (m_ack != '0) begin
        alog.push_back(m_ack);
        dlog.push_back(m_rd);
        slog.push_back(s_addr);
        clog.push_back(cyc);
      end
    end
  endtask
  task automatic slave();
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (s_en) begin
        cnt++;
        auto_ack = (cnt >= slv_wait);
        if (auto_ack) cnt = 0;
      end else begin
        cnt = 0;
        auto_ack = 0;
      end
    end
  endtask
  initial begin
    int b, bc, mb, t;
    fork
      model_loop();
      compare_loop();
      logger();
      slave();
    join_none
    step(3);
    @(negedge clk);
    chk("rst s_bus_en", 64'(s_en), 0);
    chk("rst s_wr_en", 64'(s_wr), 0);
    chk("rst s_addr", 64'(s_addr), 0);
    chk("rst s_wr_data", 64'(s_wdata), 0);
    chk("rst s_byte_en", 64'(s_be), 0);
    chk("rst m_ack", 64'(m_ack), 0);
    chk("rst m_rd_data", 64'(m_rd), 0);
    @(posedge clk);
    #1;
    rst = 1;
    slv_wait = 3;
    s_rd = 32'hDEADBEEF;
    b = alog.size();
    bc = busy_cnt;
    set_m(0, 1, 0, 0, 32'h100, 0, 4'hF);
    wait_ack(0, "t1 ack");
    set_m(0, 0, 0, 0, 0, 0, 0);
    step(3);
    chk("t1 ack count", 64'(alog.size() - b), 1);
    chk("t1 ack vec", qa(b), 64'b01);
    chk("t1 rd data", qd(b), 64'hDEADBEEF);
    chk("t1 busy cycles", 64'(busy_cnt - bc), 3);
    do_reset();
    slv_wait = 1;
    s_rd = 32'h0000_1111;
    b = alog.size();
    mb = mlog.size();
    set_m(0, 1, 0, 0, 32'h1000, 0, 4'hF);
    set_m(1, 1, 0, 0, 32'h2000, 0, 4'hF);
    t = 0;
    while (alog.size() - b < 8 && t < 200) begin
      step(1);
      t++;
    end
    set_m(0, 0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0, 0);
    step(6);
    for (int i = 0; i < 8; i++) begin
      chk("t2 dut grant", qa(b + i), (i % 2 == 1) ? 64'b10 : 64'b01);
      chk("t2 model grant", qm(mb + i), 64'(i % 2));
    end
    slv_wait = 4;
    s_rd = '0;
    b = alog.size();
    set_m(1, 1, 1, 0, 32'h200, 32'h12345678, 4'b0011);
    step(2);
    addr[1*XL +: XL] = 32'h300;
    wait_ack(1, "t3 ack");
    set_m(1, 0, 0, 0, 0, 0, 0);
    step(2);
    chk("t3 ack vec", qa(b), 64'b10);
    chk("t3 addr at ack", qs(b), 64'h200);
    slv_wait = 2;
    b = alog.size();
    set_m(1, 1, 0, 0, 32'h400, 0, 4'hF);
    set_m(0, 1, 0, 1, 32'h40, 0, 4'hF);
    wait_ack(0, "t4 lr ack");
    set_m(0, 1, 1, 0, 32'h40, 32'hA5A5A5A5, 4'hF);
    wait_ack(0, "t4 sc ack");
    set_m(0, 0, 0, 0, 0, 0, 0);
    wait_ack(1, "t4 m1 ack");
    set_m(1, 0, 0, 0, 0, 0, 0);
    step(2);
    chk("t4 grant lr", qa(b), 64'b01);
    chk("t4 grant sc", qa(b + 1), 64'b01);
    chk("t4 grant m1", qa(b + 2), 64'b10);
    chk("t4 lr to sc cycles", 64'(qc(b + 1) - qc(b)), 3);
    chk("t4 sc to m1 cycles", 64'(qc(b + 2) - qc(b + 1)), 3);
    slv_wait = 1;
    set_m(0, 1, 0, 0, 32'h500, 0, 4'hF);
    wait_ack(0, "t5 pre ack");
    set_m(0, 0, 0, 0, 0, 0, 0);
    step(2);
    slv_wait = 10;
    b = alog.size();
    set_m(1, 1, 0, 0, 32'h600, 0, 4'hF);
    step(3);
    rst = 0;
    step(1);
    @(negedge clk);
    chk("t5 s_bus_en after rst", 64'(s_en), 0);
    chk("t5 m_ack after rst", 64'(m_ack), 0);
    chk("t5 s_addr after rst", 64'(s_addr), 0);
    chk("t5 no ack pulse", 64'(alog.size() - b), 0);
    @(posedge clk);
    #1;
    rst = 1;
    slv_wait = 1;
    set_m(0, 1, 0, 0, 32'h700, 0, 4'hF);
    wait_ack(0, "t5 m0 ack");
    set_m(0, 0, 0, 0, 0, 0, 0);
    wait_ack(1, "t5 m1 ack");
    set_m(1, 0, 0, 0, 0, 0, 0);
    step(2);
    chk("t5 m0 first", qa(b), 64'b01);
    chk("t5 m1 second", qa(b + 1), 64'b10);
    step(2);
    s_rd = 32'hFFFFFFFF;
    slv_auto = 0;
    man_ack = 1;
    @(negedge clk);
    chk("t6 stray m_ack", 64'(m_ack), 0);
    chk("t6 stray rd_data", 64'(m_rd), 0);
    @(posedge clk);
    #1;
    man_ack = 0;
    slv_auto = 1;
    b = alog.size();
    set_m(1, 1, 0, 0, 32'h800, 0, 4'hF);
    wait_ack(1, "t6 post ack");
    set_m(1, 0, 0, 0, 0, 0, 0);
    step(3);
    chk("t6 post ack vec", qa(b), 64'b10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bus_rr_arbiter.md
# bus_rr_arbiter

- Round-robin arbiter that merges the single-master `bus` ports of up to `N_MASTERS` harts onto one shared slave port: data memory, peripherals or the system interconnect.
- Sits directly downstream of each core top's `bus_m` outputs (`o_bus_en`, `o_wr_en`, `o_wr_data`, `o_addr`, `o_byte_en`, `i_ack`, `i_rd_Data`) in multi-core builds.
- Latches the winning request, forwards it to the slave and returns the slave's ack only to the owner.
- Supports a lock so a master can keep ownership across an atomic read-modify-write sequence.

## Interface
Parameters:
- `N_MASTERS`, 2, number of requesting cores (2..8).
- `XLEN`, `` `XLEN`` (32), address and data width.

Ports:
- `i_clk`  in  1  clock; all logic on rising edge.
- `i_rst`  in  1  reset; synchronous, active-low.
- `i_m_bus_en`  in  N  per-master request.
- `i_m_wr_en`  in  N  per-master write (1) / read (0).
- `i_m_lock`  in  N  keep ownership after this transfer.
- `i_m_addr`  in  N*XLEN  packed addresses; master k in bits [k*XLEN +: XLEN].
- `i_m_wr_data`  in  N*XLEN  packed write data.
- `i_m_byte_en`  in  N*4  packed byte enables.
- `o_m_ack`  out  N  one-hot ack to the owner.
- `o_m_rd_data`  out  XLEN  read data, broadcast; valid only with `o_m_ack`.
- `o_s_bus_en`, `o_s_wr_en`  out  1  slave request and write flag.
- `o_s_addr`, `o_s_wr_data`  out  XLEN  slave address and write data.
- `o_s_byte_en`  out  4  slave byte enables.
- `i_s_ack`  in  1  slave completion, one-cycle pulse.
- `i_s_rd_data`  in  XLEN  slave read data, valid with `i_s_ack`.

## Operation
- State machine: IDLE, BUSY, LOCKED.
- **IDLE**
  - If any `i_m_bus_en` bit is set, pick the winner: the first requester searching from `last_grant+1` upward, with wrap-around.
  - Register the winner index and its `wr_en`, `addr`, `wr_data`, `byte_en` and `lock`, then go to BUSY.
  - With no request, stay in IDLE.
- **BUSY**
  - `o_s_*` are driven from the latched copy and `o_s_bus_en`=1.
  - Master-side changes are ignored until ack.
  - On `i_s_ack`: set `o_m_ack[grant]`=1 in the same cycle (combinational) and pass `i_s_rd_data` through to `o_m_rd_data`; set `last_grant`=grant.
  - Next state after ack: LOCKED if the latched lock=1, otherwise IDLE.
- **LOCKED**
  - Only master `grant` is considered; other requests wait.
  - When `i_m_bus_en[grant]` is set, latch its fields and go to BUSY.
  - Ownership ends after a transfer whose latched lock=0 is acked.
- **Bus rule:** a master drops `bus_en` in the cycle after its ack. A request still asserted in that cycle is treated as a new transaction.
- **Fairness:**
  - Because `last_grant` moves to the just-served master, a master that re-requests immediately loses to any other pending requester.
  - No starvation except through lock.
- **Reset mid-transfer:** state goes to IDLE, `last_grant`=N-1 (so master 0 wins first), and `o_s_bus_en` drops. No ack is produced for the aborted transfer; the slave must tolerate the abort.

## Timing
- Reset values:
  - `o_s_bus_en`=0, `o_s_wr_en`=0.
  - `o_s_addr`, `o_s_wr_data` = 0; `o_s_byte_en`=0.
  - `o_m_ack`=0, `o_m_rd_data`=0.
- Arbitration latency: request sampled at edge n gives `o_s_bus_en`=1 from cycle n+1.
- Minimum transaction: 2 cycles (zero-wait slave) plus 1 IDLE cycle between unlocked transfers. A locked master's next request is accepted in the cycle after ack.
- `o_m_ack` is never asserted outside BUSY and never to more than one master.
- `i_s_ack` outside BUSY is ignored.

## Structure
- Shared package `arvi_bus_pkg`:
  - `arb_state_t` enum: IDLE/BUSY/LOCKED.
  - `bus_req_t` struct: wr_en, addr, wr_data, byte_en, lock.
- One sub-module: `rr_pick`, a combinational N-way round-robin priority selector.
  - Inputs: request vector, last index.
  - Outputs: valid, index.

## Test plan
- **Single requester:** master 0 reads 0x100, slave acks after 3 cycles with 0xDEADBEEF.
  - `o_s_bus_en` high for cycles 1–3.
  - `o_m_ack`=2'b01 with data 0xDEADBEEF.
  - Master 1 never acked.
- **Simultaneous requests after reset:** masters 0 and 1 both request.
  - Master 0 served first, then master 1.
  - Both continuously re-request: grants alternate 0,1,0,1 over 8 transfers.
- **Latched fields:** master 1 changes `addr` from 0x200 to 0x300 while BUSY.
  - Slave sees 0x200 throughout; write data and byte_en 4'b0011 are stable.
- **Lock:** master 0 sends LR with lock=1, then SC with lock=0, while master 1 requests throughout.
  - Master 1 is not granted until the cycle after the SC ack.
- **Reset mid-transfer:** `i_rst`=0 during BUSY.
  - Next cycle: `o_s_bus_en`=0, no `o_m_ack` pulse, state IDLE, master 0 has priority.
- **Stray slave ack:** `i_s_ack` pulsed in IDLE.
  - No `o_m_ack` asserted.
